// File: rtl/sel_mux_pkg.sv
// Shared definitions for the N-way select pipeline: default sizes, pipe state
// encoding and the select-width helper.
package sel_mux_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_N_IN  = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // Select width for n sources; at least one bit.
    function automatic int unsigned sel_w_f(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sel_mux_pipe_nway_mux.sv
// Combinational N-way W-bit selector; out-of-range selects give zero data
// and raise the error flag.
module nway_mux
    import sel_mux_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned N_IN  = DEF_N_IN,
    localparam int unsigned SEL_W = sel_w_f(N_IN)
) (
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      comb_c,
    output logic                  err_c
);

    // One extra bit so every source index is representable next to sel.
    localparam int unsigned SEL_X = SEL_W + 1;

    logic [SEL_X-1:0] sel_ext;

    assign sel_ext = SEL_X'(sel);

    always_comb begin
        comb_c = '0;
        err_c  = 1'b1;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (sel_ext == SEL_X'(i)) begin
                comb_c = in_data[i*WIDTH +: WIDTH];
                err_c  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sel_mux_pipe.sv
// N-way operand selector feeding a 2-entry elastic register (main + skid)
// with valid/ready handshake and flush.
module sel_mux_pipe
    import sel_mux_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned N_IN  = DEF_N_IN,
    localparam int unsigned SEL_W = sel_w_f(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    pipe_state_e      state_q;
    pipe_state_e      state_d;

    logic [WIDTH-1:0] main_data_q;
    logic             main_err_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             skid_err_q;

    logic [WIDTH-1:0] comb_c;
    logic             err_c;

    logic             accept_c;
    logic             pop_c;
    logic             load_main_new_c;
    logic             load_main_skid_c;
    logic             load_skid_c;

    nway_mux #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_mux (
        .in_data (in_data),
        .sel     (sel),
        .comb_c  (comb_c),
        .err_c   (err_c)
    );

    // Ready comes from registered occupancy only, never from out_ready.
    assign in_ready  = (state_q != ST_FULL) & ~rst;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;

    assign accept_c  = in_valid & in_ready;
    assign pop_c     = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush forces EMPTY and wins over any accept.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept_c) state_d = ST_ONE;
                end
                ST_ONE: begin
                    if (accept_c && !pop_c)      state_d = ST_FULL;
                    else if (!accept_c && pop_c) state_d = ST_EMPTY;
                end
                ST_FULL: begin
                    if (pop_c) state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Storage load enables per state.
    always_comb begin
        load_main_new_c  = 1'b0;
        load_main_skid_c = 1'b0;
        load_skid_c      = 1'b0;
        if (!flush) begin
            unique case (state_q)
                ST_EMPTY: begin
                    load_main_new_c = accept_c;
                end
                ST_ONE: begin
                    load_main_new_c = accept_c & pop_c;
                    load_skid_c     = accept_c & ~pop_c;
                end
                ST_FULL: begin
                    load_main_skid_c = pop_c;
                end
                default: begin
                    load_main_new_c = 1'b0;
                end
            endcase
        end
    end

    // Entry payloads; main is left untouched on flush so out_data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            if (load_main_new_c) begin
                main_data_q <= comb_c;
                main_err_q  <= err_c;
            end else if (load_main_skid_c) begin
                main_data_q <= skid_data_q;
                main_err_q  <= skid_err_q;
            end
            if (load_skid_c) begin
                skid_data_q <= comb_c;
                skid_err_q  <= err_c;
            end
        end
    end

endmodule
